// File: rtl/key_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, per-channel debounce FSM with
// hold-to-repeat, and registered level/press/step/release outputs.
module key_conditioner #(
  parameter int unsigned N       = 4,
  parameter int unsigned DEB_CYC = 1000000,
  parameter int unsigned RPT_DLY = 25000000,
  parameter int unsigned RPT_PER = 10000000
) (
  input  logic         CLK,
  input  logic         RES,
  input  logic [N-1:0] KEY_N,
  output logic [N-1:0] STATE,
  output logic [N-1:0] PRESS,
  output logic [N-1:0] STEP,
  output logic [N-1:0] REL
);

  localparam int unsigned TW = 26;
  localparam logic [TW-1:0] DebLast = TW'(DEB_CYC - 1);
  localparam logic [TW-1:0] DlyLast = TW'(RPT_DLY - 1);
  localparam logic [TW-1:0] PerLast = TW'(RPT_PER - 1);
  localparam logic [TW-1:0] TmrOne  = TW'(1);

  if (DEB_CYC < 2 || DEB_CYC >= (1 << TW) || RPT_DLY < 2 || RPT_DLY >= (1 << TW) ||
      RPT_PER < 2 || RPT_PER >= (1 << TW)) begin : g_bad_params
    $error("key_conditioner: DEB_CYC, RPT_DLY and RPT_PER must lie in [2, 2^26)");
  end

  typedef enum logic [2:0] {
    StIdle,
    StDebPress,
    StHeld,
    StRepeat,
    StDebRel
  } key_state_e;

  // Synchronizer keeps the active-low sense of KEY_N; 1 = released.
  logic [N-1:0] sync_a;
  logic [N-1:0] sync_b;
  logic [N-1:0] pressed;

  always_ff @(posedge CLK) begin
    if (RES) begin
      sync_a <= '1;
      sync_b <= '1;
    end else begin
      sync_a <= KEY_N;
      sync_b <= sync_a;
    end
  end

  assign pressed = ~sync_b;

  logic [N-1:0] lvl_v;
  logic [N-1:0] press_v;
  logic [N-1:0] step_v;
  logic [N-1:0] rel_v;

  for (genvar i = 0; i < N; i++) begin : g_ch
    key_state_e    st;
    logic [TW-1:0] tmr;
    logic          lvl;
    logic          press_ev;
    logic          step_ev;
    logic          rel_ev;

    always_ff @(posedge CLK) begin
      if (RES) begin
        st       <= StIdle;
        tmr      <= '0;
        lvl      <= 1'b0;
        press_ev <= 1'b0;
        step_ev  <= 1'b0;
        rel_ev   <= 1'b0;
      end else begin
        press_ev <= 1'b0;
        step_ev  <= 1'b0;
        rel_ev   <= 1'b0;
        case (st)
          StIdle: begin
            if (pressed[i]) begin
              st  <= StDebPress;
              tmr <= '0;
            end
          end
          StDebPress: begin
            if (!pressed[i]) begin
              st <= StIdle;
            end else if (tmr == DebLast) begin
              st       <= StHeld;
              tmr      <= '0;
              lvl      <= 1'b1;
              press_ev <= 1'b1;
              step_ev  <= 1'b1;
            end else begin
              tmr <= tmr + TmrOne;
            end
          end
          StHeld: begin
            if (!pressed[i]) begin
              st  <= StDebRel;
              tmr <= '0;
            end else if (tmr == DlyLast) begin
              st      <= StRepeat;
              tmr     <= '0;
              step_ev <= 1'b1;
            end else begin
              tmr <= tmr + TmrOne;
            end
          end
          StRepeat: begin
            if (!pressed[i]) begin
              st  <= StDebRel;
              tmr <= '0;
            end else if (tmr == PerLast) begin
              tmr     <= '0;
              step_ev <= 1'b1;
            end else begin
              tmr <= tmr + TmrOne;
            end
          end
          StDebRel: begin
            // A bounce back to pressed resumes holding; the repeat delay restarts.
            if (pressed[i]) begin
              st  <= StHeld;
              tmr <= '0;
            end else if (tmr == DebLast) begin
              st     <= StIdle;
              tmr    <= '0;
              lvl    <= 1'b0;
              rel_ev <= 1'b1;
            end else begin
              tmr <= tmr + TmrOne;
            end
          end
          default: begin
            st  <= StIdle;
            tmr <= '0;
          end
        endcase
      end
    end

    assign lvl_v[i]   = lvl;
    assign press_v[i] = press_ev;
    assign step_v[i]  = step_ev;
    assign rel_v[i]   = rel_ev;
  end

  // Output stage: press appears DEB_CYC+3 edges after KEY_N is first sampled low.
  always_ff @(posedge CLK) begin
    if (RES) begin
      STATE <= '0;
      PRESS <= '0;
      STEP  <= '0;
      REL   <= '0;
    end else begin
      STATE <= lvl_v;
      PRESS <= press_v;
      STEP  <= step_v;
      REL   <= rel_v;
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: run-length debounce model checked every cycle,
// plus hand-computed event timings for each directed scenario.
module tb_key_conditioner;

  localparam int N   = 4;
  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int PER = 3;

  logic         CLK = 1'b0;
  logic         RES;
  logic [N-1:0] KEY_N;
  logic [N-1:0] STATE;
  logic [N-1:0] PRESS;
  logic [N-1:0] STEP;
  logic [N-1:0] REL;

  always #5 CLK = ~CLK;

  key_conditioner #(
    .N      (N),
    .DEB_CYC(DEB),
    .RPT_DLY(DLY),
    .RPT_PER(PER)
  ) dut (
    .CLK  (CLK),
    .RES  (RES),
    .KEY_N(KEY_N),
    .STATE(STATE),
    .PRESS(PRESS),
    .STEP (STEP),
    .REL  (REL)
  );

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  // Model: synchronized samples (1 = pressed), debounced level, run length of
  // samples disagreeing with the level, and the edge at which holding (re)started.
  logic [N-1:0] m_s1 = '0;
  logic [N-1:0] m_s2 = '0;
  bit           m_lvl  [N];
  int           m_run  [N];
  int           m_href [N];
  int           m_t = 0;
  logic [N-1:0] ev_state = '0, ev_press = '0, ev_step = '0, ev_rel = '0;
  logic [N-1:0] exp_state = '0, exp_press = '0, exp_step = '0, exp_rel = '0;

  int           n_press [N];
  int           n_step  [N];
  int           n_rel   [N];
  int           first_press [N];
  int           last_press  [N];
  int           first_rpt   [N];
  int           last_rel    [N];
  logic [N-1:0] seen_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s at cyc %0d: got %0h, required %0h", name, cyc, act, req);
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] smp;
    smp = m_s2;
    if (RES) begin
      m_s1 = '0;
      m_s2 = '0;
      {exp_state, exp_press, exp_step, exp_rel} = '0;
      {ev_state, ev_press, ev_step, ev_rel} = '0;
      for (int i = 0; i < N; i++) begin
        m_lvl[i] = 1'b0;
        m_run[i] = 0;
      end
    end else begin
      exp_state = ev_state;
      exp_press = ev_press;
      exp_step  = ev_step;
      exp_rel   = ev_rel;
      m_s2 = m_s1;
      m_s1 = ~KEY_N;
      ev_press = '0;
      ev_step  = '0;
      ev_rel   = '0;
      for (int i = 0; i < N; i++) begin
        if (!m_lvl[i]) begin
          m_run[i] = smp[i] ? m_run[i] + 1 : 0;
          if (m_run[i] == DEB + 1) begin
            m_lvl[i]    = 1'b1;
            m_run[i]    = 0;
            m_href[i]   = m_t;
            ev_press[i] = 1'b1;
            ev_step[i]  = 1'b1;
          end
        end else if (!smp[i]) begin
          m_run[i]++;
          if (m_run[i] == DEB + 1) begin
            m_lvl[i]  = 1'b0;
            m_run[i]  = 0;
            ev_rel[i] = 1'b1;
          end
        end else if (m_run[i] > 0) begin
          m_run[i]  = 0;
          m_href[i] = m_t;
        end else if ((m_t - m_href[i]) >= DLY && ((m_t - m_href[i] - DLY) % PER) == 0) begin
          ev_step[i] = 1'b1;
        end
        ev_state[i] = m_lvl[i];
      end
    end
    m_t++;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_edge();
    #1;
    check("STATE", 32'(STATE), 32'(exp_state));
    check("PRESS", 32'(PRESS), 32'(exp_press));
    check("STEP",  32'(STEP),  32'(exp_step));
    check("REL",   32'(REL),   32'(exp_rel));
    for (int i = 0; i < N; i++) begin
      if (PRESS[i]) begin
        n_press[i]++;
        if (first_press[i] < 0) first_press[i] = cyc;
        last_press[i] = cyc;
      end
      if (STEP[i]) begin
        n_step[i]++;
        if (!PRESS[i] && first_rpt[i] < 0) first_rpt[i] = cyc;
      end
      if (REL[i]) begin
        n_rel[i]++;
        last_rel[i] = cyc;
      end
    end
    seen_state |= STATE;
    cyc++;
  endtask

  task automatic clear_log();
    cyc = 0;
    seen_state = '0;
    for (int i = 0; i < N; i++) begin
      n_press[i]     = 0;
      n_step[i]      = 0;
      n_rel[i]       = 0;
      first_press[i] = -1;
      last_press[i]  = -1;
      first_rpt[i]   = -1;
      last_rel[i]    = -1;
    end
  endtask

  initial begin
    RES   = 1'b1;
    KEY_N = '1;
    clear_log();
    repeat (3) tick();
    check("reset_outputs", 32'({STATE, PRESS, STEP, REL}), 32'h0);
    RES = 1'b0;
    repeat (2) tick();

    // Key 0 held 12 cycles; key 1 bounces low for only 3 cycles.
    clear_log();
    KEY_N = 4'b1100;
    for (int k = 0; k < 26; k++) begin
      if (k == 3)  KEY_N[1] = 1'b1;
      if (k == 12) KEY_N[0] = 1'b1;
      tick();
      if (k == 11) check("state0_held", 32'(STATE[0]), 32'd1);
    end
    check("k0_press_cyc", first_press[0], 7);
    check("k0_press_cnt", n_press[0], 1);
    check("k0_step_cnt",  n_step[0], 1);
    check("k0_rel_cyc",   last_rel[0], 19);
    check("k0_rel_cnt",   n_rel[0], 1);
    check("k1_quiet",     n_press[1] + n_step[1] + n_rel[1], 0);
    check("k1_state",     32'(seen_state[1]), 32'd0);

    // Key 2 held 30 cycles: press, repeat after 10, then every 3.
    clear_log();
    KEY_N[2] = 1'b0;
    for (int k = 0; k < 45; k++) begin
      if (k == 30) KEY_N[2] = 1'b1;
      tick();
    end
    check("k2_press_cyc", first_press[2], 7);
    check("k2_first_rpt", first_rpt[2], 17);
    check("k2_step_cnt",  n_step[2], 7);
    check("k2_press_cnt", n_press[2], 1);
    check("k2_rel_cnt",   n_rel[2], 1);
    check("k2_rel_cyc",   last_rel[2], 37);

    // Key 3 held with a 2-cycle release glitch.
    clear_log();
    KEY_N[3] = 1'b0;
    for (int k = 0; k < 45; k++) begin
      if (k == 10) KEY_N[3] = 1'b1;
      if (k == 12) KEY_N[3] = 1'b0;
      if (k == 30) KEY_N[3] = 1'b1;
      tick();
    end
    check("k3_press_cnt", n_press[3], 1);
    check("k3_first_rpt", first_rpt[3], 25);
    check("k3_step_cnt",  n_step[3], 4);
    check("k3_rel_cnt",   n_rel[3], 1);
    check("k3_rel_cyc",   last_rel[3], 37);

    // Keys 0 and 3 together.
    clear_log();
    KEY_N = 4'b0110;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (k == 7) check("press_pair", 32'(PRESS), 32'h9);
    end
    KEY_N = '1;
    repeat (12) tick();
    check("pair_rel", n_rel[0] + n_rel[3], 2);

    // Reset pulse during repeat with key 1 still held.
    clear_log();
    KEY_N[1] = 1'b0;
    for (int k = 0; k < 40; k++) begin
      RES = (k == 21);
      tick();
      if (k == 21) check("mid_reset_outs", 32'({STATE, PRESS, STEP, REL}), 32'h0);
    end
    RES = 1'b0;
    check("k1_first_press", first_press[1], 7);
    check("k1_first_rpt",   first_rpt[1], 17);
    check("k1_repress_cyc", last_press[1], 29);
    check("k1_press_cnt",   n_press[1], 2);
    check("k1_no_rel",      n_rel[1], 0);
    KEY_N = '1;
    repeat (12) tick();
    check("final_state", 32'(STATE), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
